csr_initiator: RTL and testbench

CSR_INITIATOR -- requirements
Module: csr_initiator

---
 rtl/csr_initiator_pkg.sv | 29 ++
 rtl/csr_initiator_fifo.sv | 61 ++++++
 rtl/csr_initiator.sv | 188 ++++++++++++++++++
 tb/tb_csr_initiator.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_initiator_pkg.sv
// csr_initiator_pkg
// Shared types for the CSR initiator: the command opcode encoding and the
// sequencing FSM states, plus small opcode decode helpers.
// Opcode 3 is reserved and is executed exactly like a READ.
package csr_initiator_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_RSVD  = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    RES  = 2'd3
  } csr_state_e;

  function automatic logic opIsWrite(input csr_op_e op);
    return op == OP_WRITE;
  endfunction

  function automatic logic opIsPoll(input csr_op_e op);
    return op == OP_POLL;
  endfunction

endpackage

// File: rtl/csr_initiator_fifo.sv
// csr_initiator_fifo
// Synchronous command FIFO holding packed {op, addr, data, mask} entries.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   push_i, data_i write side (ignored when full)
//   pop_i          advance the head (ignored when empty)
//   data_o         current head entry
//   full_o/empty_o occupancy flags
module csr_initiator_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wrPtr_q, rdPtr_q;
  logic [PtrW:0]    count_q;
  logic             pushOk, popOk;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign pushOk  = push_i & ~full_o;
  assign popOk   = pop_i & ~empty_o;
  assign data_o  = mem_q[rdPtr_q];

  // Entry storage needs no reset; the empty flag guards stale contents.
  always_ff @(posedge clk_i) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (popOk)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/csr_initiator.sv
// csr_initiator
// Queues WRITE/READ/POLL commands and executes them one at a time on a
// valid/ready CSR request/response bus, returning READ/POLL results.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   cmd_*                  command push (op, addr, data/expected, mask)
//   res_*                  result (data, timeout flag) with valid/ready
//   csr_req_*              CSR request channel
//   csr_rsp_*              CSR response channel
//   busy_o                 commands pending or FSM active
// Build option: CSR_INITIATOR_POLL_TIMEOUT_EN enables the POLL try limit;
// without it POLL retries forever and res_timeout_o is tied low.
module csr_initiator
  import csr_initiator_pkg::*;
#(
  parameter int CsrDataWidth = 32,
  parameter int CsrAddrWidth = 32,
  parameter int CmdFifoDepth = 4,
  parameter int PollMaxTries = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_op_i,
  input  logic [CsrAddrWidth-1:0] cmd_addr_i,
  input  logic [CsrDataWidth-1:0] cmd_data_i,
  input  logic [CsrDataWidth-1:0] cmd_mask_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [CsrDataWidth-1:0] res_data_o,
  output logic                    res_timeout_o,
  output logic [CsrDataWidth-1:0] csr_req_data_o,
  output logic [CsrAddrWidth-1:0] csr_req_addr_o,
  output logic                    csr_req_write_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  input  logic [CsrDataWidth-1:0] csr_rsp_data_i,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o,
  output logic                    busy_o
);

  localparam int EntryW = 2 + CsrAddrWidth + 2 * CsrDataWidth;
  localparam int TryW   = $clog2(PollMaxTries + 1);
  localparam logic [TryW-1:0] TryMax  = TryW'(PollMaxTries);
  localparam logic [TryW-1:0] TryLast = TryW'(PollMaxTries - 1);

`ifdef CSR_INITIATOR_POLL_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  csr_state_e              state_q, state_d;
  logic [TryW-1:0]         tryCount_q, tryCount_d;
  logic [CsrDataWidth-1:0] resData_q, resData_d;
  logic                    resTimeout_q, resTimeout_d;

  logic [EntryW-1:0]       headEntry;
  logic [1:0]              headOpRaw;
  csr_op_e                 headOp;
  logic [CsrAddrWidth-1:0] headAddr;
  logic [CsrDataWidth-1:0] headData, headMask;
  logic                    fifoFull, fifoEmpty, fifoPush, fifoPop;
  logic                    headIsWrite, headIsPoll, pollMatch;
  logic                    reqValid, rspReady, resValid, rspCapture;

  assign fifoPush = cmd_valid_i & cmd_ready_o;

  csr_initiator_fifo #(
    .Width (EntryW),
    .Depth (CmdFifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifoPush),
    .data_i  ({cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i}),
    .pop_i   (fifoPop),
    .data_o  (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign {headOpRaw, headAddr, headData, headMask} = headEntry;
  assign headOp      = csr_op_e'(headOpRaw);
  assign headIsWrite = opIsWrite(headOp);
  assign headIsPoll  = opIsPoll(headOp);
  assign pollMatch   = ((csr_rsp_data_i & headMask) == (headData & headMask));

  // Sequencing: IDLE picks up the FIFO head, REQ issues it, RSP waits for
  // the read data, RES holds the result. A READ/POLL response coinciding
  // with the request handshake is consumed straight from REQ.
  always_comb begin
    state_d      = state_q;
    tryCount_d   = tryCount_q;
    resData_d    = resData_q;
    resTimeout_d = resTimeout_q;
    fifoPop      = 1'b0;
    reqValid     = 1'b0;
    rspReady     = 1'b0;
    resValid     = 1'b0;
    rspCapture   = 1'b0;
    case (state_q)
      IDLE: begin
        rspReady = 1'b1;
        if (!fifoEmpty) begin
          state_d    = REQ;
          tryCount_d = '0;
        end
      end
      REQ: begin
        reqValid = 1'b1;
        rspReady = ~headIsWrite;
        if (csr_req_ready_i) begin
          if (headIsWrite) begin
            fifoPop = 1'b1;
            state_d = IDLE;
          end else if (csr_rsp_valid_i) begin
            rspCapture = 1'b1;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        rspReady = 1'b1;
        if (csr_rsp_valid_i) rspCapture = 1'b1;
      end
      RES: begin
        resValid = 1'b1;
        if (res_ready_i) begin
          fifoPop = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A POLL mismatch re-issues the read; the counter saturates so a long
    // poll without a try limit never wraps.
    if (rspCapture) begin
      if (!headIsPoll || pollMatch) begin
        state_d      = RES;
        resData_d    = csr_rsp_data_i;
        resTimeout_d = 1'b0;
      end else begin
        if (tryCount_q != TryMax) tryCount_d = tryCount_q + 1'b1;
        if (TimeoutEn && (tryCount_q == TryLast)) begin
          state_d      = RES;
          resData_d    = csr_rsp_data_i;
          resTimeout_d = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
    end
  end

  // State and result registers, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      tryCount_q   <= '0;
      resData_q    <= '0;
      resTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tryCount_q   <= tryCount_d;
      resData_q    <= resData_d;
      resTimeout_q <= resTimeout_d;
    end
  end

  // Handshake outputs are forced low while reset is asserted; request
  // fields are zeroed outside REQ so stale FIFO contents never show.
  assign cmd_ready_o     = ~fifoFull & rst_ni;
  assign csr_req_valid_o = reqValid & rst_ni;
  assign csr_rsp_ready_o = rspReady & rst_ni;
  assign res_valid_o     = resValid & rst_ni;
  assign csr_req_addr_o  = reqValid ? headAddr : '0;
  assign csr_req_data_o  = reqValid ? headData : '0;
  assign csr_req_write_o = reqValid & headIsWrite;
  assign res_data_o      = resData_q;
  assign res_timeout_o   = TimeoutEn ? resTimeout_q : 1'b0;
  assign busy_o          = ~fifoEmpty | (state_q != IDLE);

endmodule

// File: tb/tb_csr_initiator.sv
// tb_csr_initiator
// Directed bench for csr_initiator with PollMaxTries = 8. Expected CSR
// requests and results are queued when a command is issued; a monitor
// compares them against every handshake the DUT presents. Handles builds
// with and without CSR_INITIATOR_POLL_TIMEOUT_EN.
module tb_csr_initiator;

  localparam int Dw = 32;
  localparam int Aw = 32;
  localparam int MaxTries = 8;

  typedef struct {
    logic          write;
    logic [Aw-1:0] addr;
    logic [Dw-1:0] data;
    logic          checkData;
  } req_t;

  typedef struct {
    logic [Dw-1:0] data;
    logic          timeout;
  } res_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i = '0;
  logic [Aw-1:0] cmd_addr_i = '0;
  logic [Dw-1:0] cmd_data_i = '0;
  logic [Dw-1:0] cmd_mask_i = '0;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [Dw-1:0] res_data_o;
  logic          res_timeout_o;
  logic [Dw-1:0] csr_req_data_o;
  logic [Aw-1:0] csr_req_addr_o;
  logic          csr_req_write_o;
  logic          csr_req_valid_o;
  logic          csr_req_ready_i;
  logic [Dw-1:0] csr_rsp_data_i;
  logic          csr_rsp_valid_i;
  logic          csr_rsp_ready_o;
  logic          busy_o;

  req_t expReq[$];
  res_t expRes[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   readsSeen = 0;
  int   reqSeen = 0;

  // Responder configuration, changed by the stimulus just after posedges.
  logic          readyEn = 1'b1;
  logic          resReadyEn = 1'b1;
  logic          passThrough = 1'b1;
  logic          holdRsp = 1'b0;
  logic          strayRsp = 1'b0;
  int            rspIdx = 0;
  int            highReads = 0;
  logic [Dw-1:0] highVal = '0;
  logic [Dw-1:0] lowVal = '0;

  csr_initiator #(
    .CsrDataWidth (Dw),
    .CsrAddrWidth (Aw),
    .CmdFifoDepth (4),
    .PollMaxTries (MaxTries)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_op_i        (cmd_op_i),
    .cmd_addr_i      (cmd_addr_i),
    .cmd_data_i      (cmd_data_i),
    .cmd_mask_i      (cmd_mask_i),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_data_o      (res_data_o),
    .res_timeout_o   (res_timeout_o),
    .csr_req_data_o  (csr_req_data_o),
    .csr_req_addr_o  (csr_req_addr_o),
    .csr_req_write_o (csr_req_write_o),
    .csr_req_valid_o (csr_req_valid_o),
    .csr_req_ready_i (csr_req_ready_i),
    .csr_rsp_data_i  (csr_rsp_data_i),
    .csr_rsp_valid_i (csr_rsp_valid_i),
    .csr_rsp_ready_o (csr_rsp_ready_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Push one command; waits (bounded) for cmd_ready_o.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] mask);
    int n = 0;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
    cmd_mask_i  = mask;
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    vectors++;
    if (!cmd_ready_o) begin
      miscompares++;
      $display("[TB] FAIL cmd_accept: cmd_ready_o stayed 0, expected 1 within 200 cycles");
      cmd_valid_i = 1'b0;
    end else begin
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
    end
  endtask

  // Wait until the DUT is idle and every expected transfer has been seen.
  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((busy_o || expReq.size() != 0 || expRes.size() != 0) && n < 300);
    vectors++;
    if (busy_o || expReq.size() != 0 || expRes.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s: busy=%0b reqLeft=%0d resLeft=%0d, expected idle with none left",
               name, busy_o, expReq.size(), expRes.size());
    end
    @(posedge clk_i);
    #1;
  endtask

  // CSR slave model: drives ready and read data on negedges.
  initial begin : responder
    logic          pendingRsp;
    logic [Dw-1:0] pendingData;
    pendingRsp      = 1'b0;
    pendingData     = '0;
    csr_req_ready_i = 1'b0;
    res_ready_i     = 1'b0;
    csr_rsp_valid_i = 1'b0;
    csr_rsp_data_i  = '0;
    forever begin
      @(negedge clk_i);
      csr_req_ready_i = readyEn;
      res_ready_i     = resReadyEn;
      csr_rsp_valid_i = 1'b0;
      csr_rsp_data_i  = '0;
      if (pendingRsp) begin
        csr_rsp_valid_i = 1'b1;
        csr_rsp_data_i  = pendingData;
        pendingRsp      = 1'b0;
      end
      if (strayRsp) begin
        csr_rsp_valid_i = 1'b1;
        csr_rsp_data_i  = 32'hDEAD;
        strayRsp        = 1'b0;
      end
      if (rst_ni && csr_req_valid_o && csr_req_ready_i && !csr_req_write_o && !holdRsp) begin
        if (passThrough) begin
          csr_rsp_valid_i = 1'b1;
          csr_rsp_data_i  = (rspIdx < highReads) ? highVal : lowVal;
        end else begin
          pendingRsp  = 1'b1;
          pendingData = (rspIdx < highReads) ? highVal : lowVal;
        end
        rspIdx++;
      end
    end
  end

  // Scoreboard monitor: every request/result handshake pops an expectation.
  initial begin : monitor
    req_t e;
    res_t r;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni && csr_req_valid_o && csr_req_ready_i) begin
        reqSeen++;
        if (!csr_req_write_o) readsSeen++;
        if (expReq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_req: got addr 0x%0h write %0b, expected no request",
                   csr_req_addr_o, csr_req_write_o);
        end else begin
          e = expReq.pop_front();
          checkOutput("req_write", {31'd0, csr_req_write_o}, {31'd0, e.write});
          checkOutput("req_addr", csr_req_addr_o, e.addr);
          if (e.checkData) checkOutput("req_data", csr_req_data_o, e.data);
        end
      end
      if (rst_ni && res_valid_o && res_ready_i) begin
        if (expRes.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_res: got data 0x%0h, expected no result", res_data_o);
        end else begin
          r = expRes.pop_front();
          checkOutput("res_data", res_data_o, r.data);
          checkOutput("res_timeout", {31'd0, res_timeout_o}, {31'd0, r.timeout});
        end
      end
    end
  end

  initial begin : stimulus
    int startReads;
    int startReq;
    int n;

    // Reset values.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    checkOutput("rst_res_valid", {31'd0, res_valid_o}, 32'd0);
    checkOutput("rst_req_valid", {31'd0, csr_req_valid_o}, 32'd0);
    checkOutput("rst_rsp_ready", {31'd0, csr_rsp_ready_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("post_rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("post_rst_res_data", res_data_o, 32'd0);
    checkOutput("post_rst_timeout", {31'd0, res_timeout_o}, 32'd0);
    checkOutput("post_rst_req_addr", csr_req_addr_o, 32'd0);
    checkOutput("post_rst_req_data", csr_req_data_o, 32'd0);
    checkOutput("post_rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    checkOutput("idle_rsp_ready", {31'd0, csr_rsp_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;

    // WRITE addr 0 data 1: one write request, no result.
    expReq.push_back('{write: 1'b1, addr: 32'h0, data: 32'h1, checkData: 1'b1});
    applyStimulus(2'd0, 32'h0, 32'h1, 32'h0);
    waitIdle("write_done");

    // READ addr 2, pass-through response 0x105.
    rspIdx = 0; highReads = 0; lowVal = 32'h105; passThrough = 1'b1;
    expReq.push_back('{write: 1'b0, addr: 32'h2, data: 32'h0, checkData: 1'b0});
    expRes.push_back('{data: 32'h105, timeout: 1'b0});
    applyStimulus(2'd1, 32'h2, 32'h0, 32'h0);
    waitIdle("read_done");

    // POLL bit1 == 0: bit1 high for three reads, then low; delayed responses.
    rspIdx = 0; highReads = 3; highVal = 32'h2; lowVal = 32'h0; passThrough = 1'b0;
    for (int i = 0; i < 4; i++)
      expReq.push_back('{write: 1'b0, addr: 32'h0, data: 32'h0, checkData: 1'b0});
    expRes.push_back('{data: 32'h0, timeout: 1'b0});
    startReads = readsSeen;
    applyStimulus(2'd2, 32'h0, 32'h0, 32'h2);
    waitIdle("poll_done");
    checkOutput("poll_read_count", readsSeen - startReads, 32'd4);

    // Reserved opcode behaves as READ; result held while res_ready_i is low.
    rspIdx = 0; highReads = 0; lowVal = 32'h33; passThrough = 1'b1; resReadyEn = 1'b0;
    expReq.push_back('{write: 1'b0, addr: 32'h9, data: 32'h0, checkData: 1'b0});
    expRes.push_back('{data: 32'h33, timeout: 1'b0});
    applyStimulus(2'd3, 32'h9, 32'h0, 32'h0);
    n = 0;
    while (!res_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    repeat (2) @(negedge clk_i);
    checkOutput("res_hold_valid", {31'd0, res_valid_o}, 32'd1);
    checkOutput("res_hold_data", res_data_o, 32'h33);
    @(posedge clk_i);
    #1 resReadyEn = 1'b1;
    waitIdle("rsvd_done");

    // Fill the FIFO with four writes while the CSR bus stalls.
    readyEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expReq.push_back('{write: 1'b1, addr: 32'h10 + i, data: 32'hA0 + i, checkData: 1'b1});
      applyStimulus(2'd0, 32'h10 + i, 32'hA0 + i, 32'h0);
    end
    @(negedge clk_i);
    checkOutput("full_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    checkOutput("stall_req_valid", {31'd0, csr_req_valid_o}, 32'd1);
    checkOutput("stall_req_addr", csr_req_addr_o, 32'h10);
    @(posedge clk_i);
    #1 readyEn = 1'b1;
    startReq = reqSeen;
    n = 0;
    while (reqSeen == startReq && n < 50) begin
      @(posedge clk_i);
      n++;
    end
    @(negedge clk_i);
    checkOutput("ready_after_pop", {31'd0, cmd_ready_o}, 32'd1);
    waitIdle("fifo_drain");

    // POLL that never matches.
    rspIdx = 0; highReads = 1000; highVal = 32'h2; lowVal = 32'h0; passThrough = 1'b1;
    startReads = readsSeen;
`ifdef CSR_INITIATOR_POLL_TIMEOUT_EN
    for (int i = 0; i < MaxTries; i++)
      expReq.push_back('{write: 1'b0, addr: 32'h3, data: 32'h0, checkData: 1'b0});
    expRes.push_back('{data: 32'h2, timeout: 1'b1});
    applyStimulus(2'd2, 32'h3, 32'h0, 32'h2);
    waitIdle("poll_timeout_done");
    checkOutput("poll_timeout_reads", readsSeen - startReads, MaxTries);
`else
    for (int i = 0; i < 12; i++)
      expReq.push_back('{write: 1'b0, addr: 32'h3, data: 32'h0, checkData: 1'b0});
    applyStimulus(2'd2, 32'h3, 32'h0, 32'h2);
    n = 0;
    while ((readsSeen - startReads) < 12 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    #1 readyEn = 1'b0;
    checkOutput("poll_endless_reads", readsSeen - startReads, 32'd12);
    @(negedge clk_i);
    checkOutput("poll_endless_busy", {31'd0, busy_o}, 32'd1);
    checkOutput("poll_endless_no_res", {31'd0, res_valid_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    readyEn = 1'b1;
    expReq.delete();
    @(negedge clk_i);
    checkOutput("poll_endless_rst_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i);
    #1;
`endif

    // Reset while waiting in RSP abandons the READ; a late response is dropped.
    holdRsp = 1'b1; passThrough = 1'b0;
    expReq.push_back('{write: 1'b0, addr: 32'h5, data: 32'h0, checkData: 1'b0});
    startReads = readsSeen;
    applyStimulus(2'd1, 32'h5, 32'h0, 32'h0);
    n = 0;
    while (readsSeen == startReads && n < 50) begin
      @(posedge clk_i);
      n++;
    end
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    checkOutput("midrst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    checkOutput("midrst_rsp_ready", {31'd0, csr_rsp_ready_o}, 32'd0);
    checkOutput("midrst_res_valid", {31'd0, res_valid_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    holdRsp = 1'b0;
    @(negedge clk_i);
    checkOutput("midrst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("midrst_idle_rsp_ready", {31'd0, csr_rsp_ready_o}, 32'd1);
    @(posedge clk_i);
    #1 strayRsp = 1'b1;
    repeat (4) @(negedge clk_i);
    checkOutput("stray_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("stray_no_res", {31'd0, res_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;

    // Normal READ after the abandoned command.
    rspIdx = 0; highReads = 0; lowVal = 32'hABC; passThrough = 1'b1;
    expReq.push_back('{write: 1'b0, addr: 32'h7, data: 32'h0, checkData: 1'b0});
    expRes.push_back('{data: 32'hABC, timeout: 1'b0});
    applyStimulus(2'd1, 32'h7, 32'h0, 32'h0);
    waitIdle("final_read_done");

    checkOutput("req_queue_empty", expReq.size(), 32'd0);
    checkOutput("res_queue_empty", expRes.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
